// File: rtl/coprime_checker_seq_if.sv
// Request/result bundle for the sequential binary-GCD coprimality checker.
interface coprime_checker_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd;
  logic             coprime;

  modport master (
    output start, num1, num2,
    input  busy, done, gcd, coprime
  );

  modport slave (
    input  start, num1, num2,
    output busy, done, gcd, coprime
  );
endinterface

// File: rtl/coprime_checker_seq.sv
// Sequential GCD / coprimality checker: one Stein (binary GCD) step per clock,
// result and a one-cycle done pulse on completion.
module coprime_checker_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  coprime_checker_seq_if.slave bus
);

  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] a_or_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  // Once either operand is zero the other (or both-zero) holds the odd part of the gcd.
  assign a_or_b  = a | b;
  assign result  = a_or_b << k;
  assign diff_ab = a - b;
  assign diff_ba = b - a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      k           <= '0;
      bus.gcd     <= '0;
      bus.coprime <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a        <= bus.num1;
            b        <= bus.num2;
            k        <= '0;
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (a == '0 || b == '0) begin
            bus.gcd     <= result;
            bus.coprime <= (result == {{(WIDTH-1){1'b0}}, 1'b1});
            bus.done    <= 1'b1;
            state       <= DONE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a >= b) begin
            // Both odd: the difference is even, so halving it is exact.
            a <= diff_ab >> 1;
          end else begin
            b <= diff_ba >> 1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coprime_checker_seq.sv
// Self-checking bench: directed cases on a 32-bit instance plus random pairs driven
// into 8/32/64-bit instances in parallel, compared against a Euclid reference.
module tb_coprime_checker_seq;

  localparam int LIMIT32 = 80;
  localparam int LIMITR  = 150;
  localparam int NRAND   = 300;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  coprime_checker_seq_if #(.WIDTH(8))  bus8  ();
  coprime_checker_seq_if #(.WIDTH(32)) bus32 ();
  coprime_checker_seq_if #(.WIDTH(64)) bus64 ();

  coprime_checker_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  coprime_checker_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  coprime_checker_seq #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference gcd by Euclid's remainder method, independent of the DUT's Stein steps.
  function automatic logic [63:0] refGcd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] t;
    while (y != 64'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone32(inout int lat);
    while (bus32.done !== 1'b1 && lat < LIMIT32) begin
      tick();
      lat++;
    end
  endtask

  // lat counts the accepting edge as 1; done visible after edge lat.
  task automatic applyStimulus(input logic [31:0] n1, input logic [31:0] n2, output int lat);
    bus32.num1  = n1;
    bus32.num2  = n2;
    bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    lat = 1;
    checkOutput("acceptBusy", {63'd0, bus32.busy}, 64'd1);
    waitDone32(lat);
  endtask

  task automatic directed(input string tag, input logic [31:0] n1, input logic [31:0] n2,
                          input logic [31:0] expGcd, input int exactLat);
    int lat;
    applyStimulus(n1, n2, lat);
    checkOutput({tag, ".done"}, {63'd0, bus32.done}, 64'd1);
    checkOutput({tag, ".gcd"}, {32'd0, bus32.gcd}, {32'd0, expGcd});
    checkOutput({tag, ".coprime"}, {63'd0, bus32.coprime}, {63'd0, expGcd == 32'd1});
    if (exactLat > 0)
      checkOutput({tag, ".lat"}, 64'(lat), 64'(exactLat));
    else
      checkOutput({tag, ".latOk"}, {63'd0, lat <= 66}, 64'd1);
    tick();
    checkOutput({tag, ".donePulse"}, {63'd0, bus32.done}, 64'd0);
    checkOutput({tag, ".idleBusy"}, {63'd0, bus32.busy}, 64'd0);
    checkOutput({tag, ".gcdHold"}, {32'd0, bus32.gcd}, {32'd0, expGcd});
  endtask

  logic [63:0] op1, op2, xr, yr, gr;
  logic [63:0] g8, g32, g64;
  logic        c8, c32, c64, d8, d32, d64;
  int          l8, l32, l64, lat, sel, doneSeen;

  initial begin
    rst_n = 1'b0;
    bus8.start = 1'b0;  bus8.num1 = '0;  bus8.num2 = '0;
    bus32.start = 1'b0; bus32.num1 = '0; bus32.num2 = '0;
    bus64.start = 1'b0; bus64.num1 = '0; bus64.num2 = '0;
    #1;
    checkOutput("rst.busy", {63'd0, bus32.busy}, 64'd0);
    checkOutput("rst.done", {63'd0, bus32.done}, 64'd0);
    checkOutput("rst.gcd", {32'd0, bus32.gcd}, 64'd0);
    checkOutput("rst.coprime", {63'd0, bus32.coprime}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    directed("p17_23", 32'd17, 32'd23, 32'd1, 0);
    directed("p12_18", 32'd12, 32'd18, 32'd6, 0);
    directed("p18_12", 32'd18, 32'd12, 32'd6, 0);
    directed("p0_7", 32'd0, 32'd7, 32'd7, 2);
    directed("p7_0", 32'd7, 32'd0, 32'd7, 2);
    directed("p0_1", 32'd0, 32'd1, 32'd1, 2);
    directed("p0_0", 32'd0, 32'd0, 32'd0, 2);
    directed("pMax", 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 0);
    directed("pPow2", 32'h80000000, 32'h40000000, 32'h40000000, 0);
    // Back-to-back: second start immediately after the first returns to IDLE.
    directed("pBack", 32'd1071, 32'd462, 32'd21, 0);

    // Start held high with operands changing during CALC.
    bus32.num1  = 32'd1071;
    bus32.num2  = 32'd462;
    bus32.start = 1'b1;
    tick();
    lat = 1;
    while (bus32.done !== 1'b1 && lat < LIMIT32) begin
      bus32.num1 = $urandom;
      bus32.num2 = $urandom;
      tick();
      lat++;
    end
    checkOutput("hold.done", {63'd0, bus32.done}, 64'd1);
    checkOutput("hold.gcd", {32'd0, bus32.gcd}, 64'd21);
    bus32.num1 = 32'd12;
    bus32.num2 = 32'd18;
    tick();
    checkOutput("hold.idle", {63'd0, bus32.busy}, 64'd0);
    checkOutput("hold.gcdKept", {32'd0, bus32.gcd}, 64'd21);
    tick();
    checkOutput("hold.reaccept", {63'd0, bus32.busy}, 64'd1);
    bus32.start = 1'b0;
    bus32.num1  = 32'd5;
    bus32.num2  = 32'd10;
    lat = 1;
    waitDone32(lat);
    checkOutput("hold2.done", {63'd0, bus32.done}, 64'd1);
    checkOutput("hold2.gcd", {32'd0, bus32.gcd}, 64'd6);
    checkOutput("hold2.coprime", {63'd0, bus32.coprime}, 64'd0);
    tick();

    // Reset pulse in the middle of a computation.
    bus32.num1  = 32'd1071;
    bus32.num2  = 32'd462;
    bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    tick();
    tick();
    checkOutput("abort.busyBefore", {63'd0, bus32.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", {63'd0, bus32.busy}, 64'd0);
    checkOutput("abort.done", {63'd0, bus32.done}, 64'd0);
    checkOutput("abort.gcd", {32'd0, bus32.gcd}, 64'd0);
    checkOutput("abort.coprime", {63'd0, bus32.coprime}, 64'd0);
    tick();
    checkOutput("abort.doneHeld", {63'd0, bus32.done}, 64'd0);
    rst_n = 1'b1;
    directed("abort.restart", 32'd1071, 32'd462, 32'd21, 0);

    // Random pairs into all three widths at once.
    for (int i = 0; i < NRAND; i++) begin
      sel = $urandom_range(0, 7);
      gr  = 64'($urandom_range(1, 255));
      xr  = {$urandom, $urandom} >> $urandom_range(0, 63);
      yr  = {$urandom, $urandom} >> $urandom_range(0, 63);
      op1 = xr * gr;
      op2 = yr * gr;
      if (sel == 0) op1 = '0;
      if (sel == 1) op2 = '0;
      if (sel == 2) op2 = op1;
      if (sel == 3) begin op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; end
      bus8.num1  = op1[7:0];  bus8.num2  = op2[7:0];
      bus32.num1 = op1[31:0]; bus32.num2 = op2[31:0];
      bus64.num1 = op1;       bus64.num2 = op2;
      bus8.start = 1'b1; bus32.start = 1'b1; bus64.start = 1'b1;
      tick();
      bus8.start = 1'b0; bus32.start = 1'b0; bus64.start = 1'b0;
      d8 = 1'b0; d32 = 1'b0; d64 = 1'b0;
      l8 = 0; l32 = 0; l64 = 0;
      g8 = '0; g32 = '0; g64 = '0;
      c8 = 1'b0; c32 = 1'b0; c64 = 1'b0;
      for (int c = 2; c <= LIMITR && !(d8 && d32 && d64); c++) begin
        tick();
        if (!d8 && bus8.done === 1'b1) begin
          d8 = 1'b1; l8 = c; g8 = {56'd0, bus8.gcd}; c8 = bus8.coprime;
        end
        if (!d32 && bus32.done === 1'b1) begin
          d32 = 1'b1; l32 = c; g32 = {32'd0, bus32.gcd}; c32 = bus32.coprime;
        end
        if (!d64 && bus64.done === 1'b1) begin
          d64 = 1'b1; l64 = c; g64 = bus64.gcd; c64 = bus64.coprime;
        end
      end
      tick();
      gr = refGcd({56'd0, op1[7:0]}, {56'd0, op2[7:0]});
      checkOutput("rand8.done", {63'd0, d8}, 64'd1);
      checkOutput("rand8.gcd", g8, gr);
      checkOutput("rand8.coprime", {63'd0, c8}, {63'd0, gr == 64'd1});
      checkOutput("rand8.lat", {63'd0, l8 <= 2*8+2}, 64'd1);
      gr = refGcd({32'd0, op1[31:0]}, {32'd0, op2[31:0]});
      checkOutput("rand32.done", {63'd0, d32}, 64'd1);
      checkOutput("rand32.gcd", g32, gr);
      checkOutput("rand32.coprime", {63'd0, c32}, {63'd0, gr == 64'd1});
      checkOutput("rand32.lat", {63'd0, l32 <= 2*32+2}, 64'd1);
      gr = refGcd(op1, op2);
      checkOutput("rand64.done", {63'd0, d64}, 64'd1);
      checkOutput("rand64.gcd", g64, gr);
      checkOutput("rand64.coprime", {63'd0, c64}, {63'd0, gr == 64'd1});
      checkOutput("rand64.lat", {63'd0, l64 <= 2*64+2}, 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL timeout: simulation did not complete, errors so far %0d", errorCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
